// File: rtl/imem_loader.sv
// Boot-time program loader: receives a framed byte stream, writes big-endian
// 16-bit words into instruction memory from address 0, and holds the CPU in reset until a checksummed load completes.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, so the loader never stalls mid-frame.

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state, state_next;
  logic              xfer;
  logic              receiving;
  logic              start_ok;
  logic [7:0]        len_hi_q;
  logic [7:0]        hi_q;
  logic [7:0]        chk_q;
  logic [15:0]       len_q;
  logic [15:0]       len_word;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic              last_word;

  assign receiving = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA_HI) || (state == S_DATA_LO) ||
                     (state == S_CHECK);
  assign in_ready  = receiving;
  assign busy      = receiving;
  assign cpu_hold  = receiving || (state == S_ERR);
  assign err       = (state == S_ERR);
  assign dbg_state = state;

  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_word  = {len_hi_q, in_data};
  // One counter serves as both word count and write address.
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (16'(cnt_inc) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_next = S_LEN_HI;
      S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, len_word} > CAP) state_next = S_ERR;
          else if (len_word == 16'd0) state_next = S_CHECK;
          else                        state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) state_next = S_DATA_LO;
      S_DATA_LO: if (xfer) state_next = last_word ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (xfer) state_next = (in_data == chk_q) ? S_DONE : S_ERR;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      cnt_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start_ok) begin
        chk_q <= '0;
        cnt_q <= '0;
      end
      // The checksum byte itself is compared, not accumulated.
      if (xfer && state != S_CHECK) chk_q <= chk_q ^ in_data;
      case (state)
        S_LEN_HI:  if (xfer) len_hi_q <= in_data;
        S_LEN_LO:  if (xfer) len_q <= len_word;
        S_DATA_HI: if (xfer) hi_q <= in_data;
        S_DATA_LO: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt_q[ADDR_W-1:0];
            imem_wdata <= {hi_q, in_data};
            cnt_q      <= cnt_inc;
          end
        end
        S_CHECK:   if (xfer && in_data == chk_q) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a frame-level
// model of expected writes, checksum outcome and status outputs.
module tb_imem_loader;
  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;
  localparam int W      = ADDR_W + 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [15:0]  imem[CAP];
  logic [15:0]  words[CAP];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the next expected (addr, data)
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL write_content: got addr=%0h data=%04h, expected addr=%0h data=%04h",
                   imem_addr, imem_wdata, mon_exp[W-1:16], mon_exp[15:0]);
        end
      end
      imem[imem_addr] = imem_wdata;
    end
  end

  // driver tasks (all called and returning at a falling edge)
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, budget);
      in_valid = 1'b0;
      start    = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, cpu_hold, in_ready, err, done} !== 5'b11100) begin
      n_fail++;
      $display("FAIL start_status: got busy/hold/ready/err/done=%b, expected 11100",
               {busy, cpu_hold, in_ready, err, done});
    end
  endtask

  // Sends one frame of `len` words from words[] and checks the outcome the
  // frame rules predict: oversize -> ERR after LEN, bad CHK -> ERR, else DONE.
  task automatic run_frame(input int len, input bit bad_chk, input bit gaps, input bit start_mid);
    logic [15:0] len_w;
    logic [7:0]  chk;
    len_w = len[15:0];
    chk   = 8'h00;
    do_start();
    chk ^= len_w[15:8];
    send_byte(len_w[15:8], gaps, 1'b0);
    chk ^= len_w[7:0];
    send_byte(len_w[7:0], gaps, 1'b0);
    if (len > CAP) begin
      n_checks++;
      if ({err, in_ready, busy, cpu_hold, done} !== 5'b10010) begin
        n_fail++;
        $display("FAIL oversize_status: got err/ready/busy/hold/done=%b, expected 10010",
                 {err, in_ready, busy, cpu_hold, done});
      end
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({err, in_ready, cpu_hold} !== 3'b101) begin
        n_fail++;
        $display("FAIL oversize_sticky: got err/ready/hold=%b, expected 101", {err, in_ready, cpu_hold});
      end
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({i[ADDR_W-1:0], words[i]});
      chk ^= words[i][15:8];
      send_byte(words[i][15:8], gaps, start_mid && i == 0);
      n_checks++;
      if (imem_we !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hi_no_write: got we=%b busy=%b, expected we=0 busy=1", imem_we, busy);
      end
      chk ^= words[i][7:0];
      send_byte(words[i][7:0], gaps, 1'b0);
      n_checks++;
      if (imem_we !== 1'b1) begin
        n_fail++;
        $display("FAIL lo_write_strobe: got we=%b word=%0d, expected 1", imem_we, i);
      end
    end
    send_byte(bad_chk ? (chk ^ 8'h01) : chk, gaps, 1'b0);
    n_checks++;
    if (!bad_chk) begin
      if ({done, busy, cpu_hold, err, in_ready} !== 5'b10000) begin
        n_fail++;
        $display("FAIL good_chk_status: got done/busy/hold/err/ready=%b, expected 10000",
                 {done, busy, cpu_hold, err, in_ready});
      end
    end else begin
      if ({done, busy, cpu_hold, err, in_ready} !== 5'b00110) begin
        n_fail++;
        $display("FAIL bad_chk_status: got done/busy/hold/err/ready=%b, expected 00110",
                 {done, busy, cpu_hold, err, in_ready});
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || err !== bad_chk || cpu_hold !== bad_chk) begin
      n_fail++;
      $display("FAIL after_chk: got done=%b err=%b hold=%b, expected done=0 err=%b hold=%b",
               done, err, cpu_hold, bad_chk, bad_chk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL writes_pending: got %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_random_words();
    for (int i = 0; i < CAP; i++) words[i] = 16'($urandom_range(0, 65535));
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b we=%b addr=%0h data=%04h hold=%b busy=%b done=%b err=%b, expected all 0",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, busy, cpu_hold, err, done} !== 5'b00000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got ready/busy/hold/err/done=%b, expected 00000",
               {in_ready, busy, cpu_hold, err, done});
    end
  endtask

  task automatic test_two_word();
    words[0] = 16'h0123;
    words[1] = 16'h5040;
    run_frame(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    words[0] = 16'h0123;
    words[1] = 16'h5040;
    run_frame(2, 1'b1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_and_oversize();
    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h0101, 1'b0, 1'b0, 1'b0);
    run_frame(CAP + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_with_gaps();
    int bad;
    fill_random_words();
    for (int i = 0; i < CAP; i++) imem[i] = 16'hxxxx;
    run_frame(CAP, 1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < CAP; i++) if (imem[i] !== words[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_mem_image: got %0d wrong words, expected 0", bad);
    end
  endtask

  task automatic test_start_while_busy();
    fill_random_words();
    run_frame(3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_mid: got ready=%b we=%b addr=%0h data=%04h hold=%b busy=%b done=%b err=%b, expected all 0",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random_words();
    run_frame(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 8; n++) begin
      fill_random_words();
      run_frame($urandom_range(0, CAP), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_zero_and_oversize();
    test_full_with_gaps();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random_frames();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
